// File: rtl/common_pkg.sv
// Shared pipeline types: control bundle, memory FSM states and funct3 codes.
// Imported by the memory stage and its load aligner.
package common;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } control_type;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RD
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] f3,
                                      input logic is_store);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Extracts and extends the addressed byte/half/word from a read data word.
// Purely combinational so it can also serve a forwarding path.
module load_aligner
    import common::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        b       = shifted[7:0];
        h       = addr[1] ? rdata[31:16] : rdata[15:0];
        data    = '0;
        unique case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_W:    data = rdata;
            F3_BU:   data = {24'h0, b};
            F3_HU:   data = {16'h0, h};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory-access stage: issues loads/stores on a handshaked data port,
// stalls upstream while a bus access is outstanding, registers the WB bundle.
module memory_stage
    import common::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  control_type control_in,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    output logic        stall,
    output logic        valid_out,
    output control_type control_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        access_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    control_type ctrl_q, ctrl_d;

    logic        vo_q, vo_d;
    control_type co_q, co_d;
    logic [31:0] ao_q, ao_d;
    logic [31:0] ld_q, ld_d;
    logic        mis_q, mis_d;
    logic        af_q, af_d;

    logic        stall_c;
    logic        mem_op, mis_c, legal_c, done, expire;
    logic [31:0] aligned;

    load_aligner u_align (
        .rdata  (dmem_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (ctrl_q.funct3),
        .data   (aligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        req_d   = req_q;
        ctrl_d  = ctrl_q;
        vo_d    = 1'b0;
        co_d    = '0;
        ao_d    = '0;
        ld_d    = '0;
        mis_d   = 1'b0;
        af_d    = 1'b0;
        stall_c = 1'b0;
        done    = 1'b0;
        expire  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        mem_op  = control_in.mem_read | control_in.mem_write;
        legal_c = f3_legal(control_in.funct3, control_in.mem_write);
        mis_c   = ((control_in.funct3[1:0] == 2'b01) && alu_data[0]) ||
                  ((control_in.funct3[1:0] == 2'b10) &&
                   (alu_data[1:0] != 2'b00));

        unique case (state_q)
            IDLE: begin
                if (valid_in && !mem_op) begin
                    vo_d = 1'b1;
                    co_d = control_in;
                    ao_d = alu_data;
                end else if (valid_in && (mis_c || !legal_c)) begin
                    vo_d = 1'b1;
                    co_d = control_in;
                    co_d.reg_write = 1'b0;
                    ao_d  = alu_data;
                    mis_d = mis_c;
                    af_d  = !legal_c;
                end else if (valid_in) begin
                    stall_c = 1'b1;
                    state_d = REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    addr_d  = alu_data;
                    ctrl_d  = control_in;
                    we_d    = control_in.mem_write;
                    be_d    = 4'b1111;
                    wdata_d = memory_data;
                    if (control_in.mem_write) begin
                        unique case (control_in.funct3[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << alu_data[1:0];
                                wdata_d = {4{memory_data[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << {alu_data[1], 1'b0};
                                wdata_d = {2{memory_data[15:0]}};
                            end
                            default: be_d = 4'b1111;
                        endcase
                    end
                end
            end
            REQ, WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == REQ) begin
                    done = dmem_ready && (we_q || dmem_rvalid);
                end else begin
                    done = dmem_rvalid;
                end
                stall_c = !(done || expire);
                // Completion beats a timeout landing in the same cycle.
                if (done) begin
                    vo_d    = 1'b1;
                    co_d    = ctrl_q;
                    ao_d    = addr_q;
                    ld_d    = we_q ? 32'h0 : aligned;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (expire) begin
                    vo_d = 1'b1;
                    co_d = ctrl_q;
                    co_d.reg_write = 1'b0;
                    ao_d    = addr_q;
                    af_d    = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (state_q == REQ && dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = WAIT_RD;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            ctrl_q  <= '0;
            vo_q    <= 1'b0;
            co_q    <= '0;
            ao_q    <= '0;
            ld_q    <= '0;
            mis_q   <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            req_q   <= req_d;
            ctrl_q  <= ctrl_d;
            vo_q    <= vo_d;
            co_q    <= co_d;
            ao_q    <= ao_d;
            ld_q    <= ld_d;
            mis_q   <= mis_d;
            af_q    <= af_d;
        end
    end

    assign stall        = stall_c & ~rst;
    assign valid_out    = vo_q;
    assign control_out  = co_q;
    assign alu_data_out = ao_q;
    assign load_data    = ld_q;
    assign misaligned   = mis_q;
    assign access_fault = af_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = {addr_q[31:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pass-through, stores, loads, faults,
// timeout and mid-access reset, each with hand-computed expectations.
module tb_memory_stage;
    import common::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    control_type control_in;
    logic [31:0] alu_data;
    logic [31:0] memory_data;
    logic        stall;
    logic        valid_out;
    control_type control_out;
    logic [31:0] alu_data_out;
    logic [31:0] load_data;
    logic        misaligned;
    logic        access_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int total = 0;
    int bad   = 0;

    memory_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .control_in   (control_in),
        .alu_data     (alu_data),
        .memory_data  (memory_data),
        .stall        (stall),
        .valid_out    (valid_out),
        .control_out  (control_out),
        .alu_data_out (alu_data_out),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic control_type mkc(input logic rw, input logic mr,
                                        input logic mw,
                                        input logic [2:0] f3);
        control_type c;
        c.reg_write = rw;
        c.mem_read  = mr;
        c.mem_write = mw;
        c.funct3    = f3;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input control_type c, input logic [31:0] a,
                         input logic [31:0] d);
        valid_in    = 1'b1;
        control_in  = c;
        alu_data    = a;
        memory_data = d;
    endtask

    task automatic idle_in();
        valid_in    = 1'b0;
        control_in  = '0;
        alu_data    = '0;
        memory_data = '0;
    endtask

    task automatic mem(input logic rdy, input logic rv,
                       input logic [31:0] rd);
        dmem_ready  = rdy;
        dmem_rvalid = rv;
        dmem_rdata  = rd;
    endtask

    // Load that completes with ready+rvalid in its first REQ cycle.
    task automatic fast_load(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] rd,
                             input logic [31:0] exp);
        drive(mkc(1'b1, 1'b1, 1'b0, f3), a, 32'h0);
        @(negedge clk);
        chk({tag, "_acc_stall"}, 32'(stall), 32'd1);
        step();
        idle_in();
        mem(1'b1, 1'b1, rd);
        @(negedge clk);
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        step();
        mem(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_data"}, load_data, exp);
    endtask

    int reqs;

    initial begin
        rst = 1'b1;
        idle_in();
        mem(1'b0, 1'b0, 32'h0);
        repeat (2) step();
        @(negedge clk);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ctrl", 32'(control_out), 32'd0);
        step();
        rst = 1'b0;

        // ALU pass-through
        drive(mkc(1'b1, 1'b0, 1'b0, 3'b000), 32'h1234, 32'h0);
        @(negedge clk);
        chk("alu_stall", 32'(stall), 32'd0);
        step();
        idle_in();
        @(negedge clk);
        chk("alu_valid", 32'(valid_out), 32'd1);
        chk("alu_data", alu_data_out, 32'h1234);
        chk("alu_rw", 32'(control_out.reg_write), 32'd1);
        chk("alu_stall2", 32'(stall), 32'd0);

        // SB 0x103 with two wait cycles
        step();
        drive(mkc(1'b0, 1'b0, 1'b1, F3_B), 32'h103, 32'hAB);
        @(negedge clk);
        chk("sb_acc_stall", 32'(stall), 32'd1);
        step();
        idle_in();
        @(negedge clk);
        chk("sb_req", 32'(dmem_req), 32'd1);
        chk("sb_we", 32'(dmem_we), 32'd1);
        chk("sb_be", 32'(dmem_be), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_w1_stall", 32'(stall), 32'd1);
        step();
        @(negedge clk);
        chk("sb_w2_stall", 32'(stall), 32'd1);
        chk("sb_w2_be", 32'(dmem_be), 32'h8);
        step();
        mem(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("sb_rdy_stall", 32'(stall), 32'd0);
        step();
        mem(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("sb_valid", 32'(valid_out), 32'd1);
        chk("sb_req_drop", 32'(dmem_req), 32'd0);
        chk("sb_ld", load_data, 32'h0);

        // SH upper half
        step();
        drive(mkc(1'b0, 1'b0, 1'b1, F3_H), 32'h206, 32'h1234BEEF);
        step();
        idle_in();
        @(negedge clk);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        mem(1'b1, 1'b0, 32'h0);
        step();
        mem(1'b0, 1'b0, 32'h0);

        // Loads
        step();
        fast_load("lb", F3_B, 32'h101, 32'h00008000, 32'hFFFFFF80);
        step();
        fast_load("lhu", F3_HU, 32'h102, 32'hBEEF0000, 32'h0000BEEF);
        step();
        fast_load("lh", F3_H, 32'h102, 32'hBEEF0000, 32'hFFFFBEEF);

        // LBU via 1-cycle memory: ready, then rvalid
        step();
        drive(mkc(1'b1, 1'b1, 1'b0, F3_BU), 32'h101, 32'h0);
        step();
        idle_in();
        mem(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lbu_be", 32'(dmem_be), 32'hF);
        chk("lbu_req_stall", 32'(stall), 32'd1);
        step();
        mem(1'b0, 1'b1, 32'h00008000);
        @(negedge clk);
        chk("lbu_wait_req", 32'(dmem_req), 32'd0);
        chk("lbu_wait_stall", 32'(stall), 32'd0);
        step();
        mem(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lbu_data", load_data, 32'h00000080);
        chk("lbu_valid", 32'(valid_out), 32'd1);

        // Misaligned LW
        step();
        drive(mkc(1'b1, 1'b1, 1'b0, F3_W), 32'h102, 32'h0);
        @(negedge clk);
        chk("mis_stall", 32'(stall), 32'd0);
        step();
        idle_in();
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_valid", 32'(valid_out), 32'd1);
        chk("mis_rw", 32'(control_out.reg_write), 32'd0);
        chk("mis_ld", load_data, 32'h0);

        // Illegal load funct3 011
        step();
        drive(mkc(1'b1, 1'b1, 1'b0, 3'b011), 32'h100, 32'h0);
        @(negedge clk);
        chk("ill_stall", 32'(stall), 32'd0);
        step();
        idle_in();
        @(negedge clk);
        chk("ill_fault", 32'(access_fault), 32'd1);
        chk("ill_req", 32'(dmem_req), 32'd0);
        chk("ill_rw", 32'(control_out.reg_write), 32'd0);

        // Timeout: ready never arrives
        step();
        drive(mkc(1'b1, 1'b1, 1'b0, F3_W), 32'h300, 32'h0);
        step();
        idle_in();
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_out) break;
            if (dmem_req) reqs++;
        end
        chk("to_valid", 32'(valid_out), 32'd1);
        chk("to_req_cycles", 32'(reqs), 32'd16);
        chk("to_fault", 32'(access_fault), 32'd1);
        chk("to_rw", 32'(control_out.reg_write), 32'd0);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        step();
        mem(1'b0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        chk("stray_stall", 32'(stall), 32'd0);
        step();
        mem(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("stray_valid", 32'(valid_out), 32'd0);
        chk("stray_ld", load_data, 32'h0);
        chk("stray_req", 32'(dmem_req), 32'd0);

        // Reset while in WAIT_RD
        step();
        drive(mkc(1'b1, 1'b1, 1'b0, F3_W), 32'h200, 32'h0);
        step();
        idle_in();
        mem(1'b1, 1'b0, 32'h0);
        step();
        mem(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("wr_stall", 32'(stall), 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_stall", 32'(stall), 32'd0);
        step();
        @(negedge clk);
        chk("rstw_valid", 32'(valid_out), 32'd0);
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_ld", load_data, 32'h0);
        chk("rstw_alu", alu_data_out, 32'h0);
        chk("rstw_fault", 32'(access_fault), 32'd0);
        step();
        rst = 1'b0;
        fast_load("lw", F3_W, 32'h200, 32'hCAFEF00D, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
